mem_port_arbiter: RTL and testbench

Shares the single unified instruction/data memory port of the multicycle core between two requesters. Requester 0 is the core's memory interface (IF/MemRead/MemWrite accesses). Requester 1 is the program loader / debug port. The block latches one request, sequences a fixed-latency memory access, and returns a one-cycle ack with read data. It also exports a stall signal that freezes the multicycle control unit's state register while the core's access is pending.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified instruction/data memory port between
// the core (requester 0) and the loader/debug port (requester 1). One request
// is latched in IDLE, a single-cycle mem_en strobe is issued, the fixed memory
// latency is counted down and a one-cycle ack returns the read data.
// Optional build macro ARB_RR_EN: round-robin arbitration on contention
// (default build: fixed priority to requester 0).

module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              core_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant_id
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

   logic [1:0]        state_q, state_d;
   logic [3:0]        lat_cnt_q, lat_cnt_d;
   logic              we_q, we_d;
   logic              grant_q, grant_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              elig0_s, elig1_s, pick1_s;
`ifdef ARB_RR_EN
   logic              last_grant_q, last_grant_d;
`endif

   // Eligibility masks a requester during its own ack cycle; pick the winner.
   always_comb begin
      elig0_s = req0 & ~ack0_q;
      elig1_s = req1 & ~ack1_q;
`ifdef ARB_RR_EN
      pick1_s = elig1_s & (~elig0_s | ~last_grant_q);
`else
      pick1_s = elig1_s & ~elig0_s;
`endif
   end

   // Access sequencer: next state, latched request and registered outputs.
   always_comb begin
      state_d     = state_q;
      lat_cnt_d   = lat_cnt_q;
      we_d        = we_q;
      grant_d     = grant_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
`ifdef ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (elig0_s | elig1_s) begin
               state_d     = S_ISSUE;
               grant_d     = pick1_s;
               we_d        = pick1_s ? we1 : we0;
               mem_addr_d  = pick1_s ? addr1 : addr0;
               mem_wdata_d = pick1_s ? wdata1 : wdata0;
`ifdef ARB_RR_EN
               last_grant_d = pick1_s;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            lat_cnt_d = LAT_LOAD;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (lat_cnt_q == 4'd0) begin
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end else begin
                  rdata_d = rdata_q;
               end
               ack0_d  = ~grant_q;
               ack1_d  = grant_q;
               state_d = S_IDLE;
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      mem_en_d = (state_d == S_ISSUE);
      mem_we_d = (state_d == S_ISSUE) & we_d;
      busy_d   = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset (aborts any access).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         lat_cnt_q   <= 4'd0;
         we_q        <= 1'b0;
         grant_q     <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
`ifdef ARB_RR_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         lat_cnt_q   <= lat_cnt_d;
         we_q        <= we_d;
         grant_q     <= grant_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         busy_q      <= busy_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
`ifdef ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign rdata      = rdata_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign busy       = busy_q;
   assign grant_id   = grant_q;
   assign core_stall = req0 & ~ack0_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT=3). A transaction-level
// model predicts every output from the grant cycle of the current access;
// directed sequences pin the model with literal expectations, then random
// traffic with occasional resets runs against the same model.

module tb_mem_port_arbiter;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = 32'd0, wdata0 = 32'd0, addr1 = 32'd0, wdata1 = 32'd0;
   logic [31:0] mem_rdata = 32'd0;
   logic        ack0, ack1, core_stall, mem_en, mem_we, busy, grant_id;
   logic [31:0] rdata, mem_addr, mem_wdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .core_stall(core_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .grant_id(grant_id)
   );

   int n_chk = 0;
   int n_pass = 0;
   bit chk_on = 1'b0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- transaction-level model ----------------
   logic [31:0] mem [logic [31:0]];
   int          m_cyc = 0;
   int          m_g = -1;          // cycle in which the current access was granted
   bit          m_owner = 1'b0, m_we = 1'b0, m_gid = 1'b0, m_last = 1'b1;
   logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_data = 32'd0, m_rdata = 32'd0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   function automatic bit e_busy();
      return (m_g >= 0) && (m_cyc > m_g) && (m_cyc <= m_g + LAT + 1);
   endfunction
   function automatic bit e_en();
      return (m_g >= 0) && (m_cyc == m_g + 1);
   endfunction
   function automatic bit e_ack(input bit o);
      return (m_g >= 0) && (m_cyc == m_g + LAT + 2) && (m_owner == o);
   endfunction

   task automatic model_step();
      bit e0, e1, w;
      if (rst) begin
         m_g = -1; m_we = 1'b0; m_gid = 1'b0; m_last = 1'b1;
         m_addr = 32'd0; m_wdata = 32'd0; m_rdata = 32'd0;
      end else begin
         if ((m_g >= 0) && (m_cyc == m_g + LAT + 1) && !m_we) m_rdata = m_data;
         if (!e_busy()) begin
            e0 = req0 && !e_ack(1'b0);
            e1 = req1 && !e_ack(1'b1);
            if (e0 || e1) begin
               w = e1 && !e0;
`ifdef ARB_RR_EN
               if (e0 && e1) w = ~m_last;
`endif
               m_owner = w; m_gid = w; m_last = w; m_g = m_cyc;
               m_we    = w ? we1 : we0;
               m_addr  = w ? addr1 : addr0;
               m_wdata = w ? wdata1 : wdata0;
               if (m_we) mem[m_addr] = m_wdata;
               else m_data = mem_rd(m_addr);
            end
         end
      end
      m_cyc++;
   endtask

   // ---------------- memory responder ----------------
   bit          pv [LAT];
   logic [31:0] pd [LAT];
   bit          cap_en = 1'b0, cap_we = 1'b0;
   logic [31:0] cap_addr = 32'd0;

   task automatic mem_respond();
      for (int i = LAT - 1; i > 0; i--) begin
         pv[i] = pv[i-1];
         pd[i] = pd[i-1];
      end
      pv[0] = cap_en && !cap_we;
      pd[0] = mem_rd(cap_addr);
      mem_rdata = pv[LAT-1] ? pd[LAT-1] : $urandom();
   endtask

   task automatic next_cycle();
      @(posedge clk);
      model_step();
      #1;
      mem_respond();
   endtask

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         cap_en = mem_en; cap_we = mem_we; cap_addr = mem_addr;
         chk1("ack0", ack0, e_ack(1'b0));
         chk1("ack1", ack1, e_ack(1'b1));
         chk1("busy", busy, e_busy());
         chk1("mem_en", mem_en, e_en());
         chk1("mem_we", mem_we, e_en() && m_we);
         chk1("grant_id", grant_id, m_gid);
         chk1("core_stall", core_stall, req0 && !e_ack(1'b0));
         chk32("mem_addr", mem_addr, m_addr);
         chk32("mem_wdata", mem_wdata, m_wdata);
         chk32("rdata", rdata, m_rdata);
      end
   end

   initial begin
      int cnt, a0_at, a1_at;
      bit s0, s1;
      for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = 32'd0; end
      next_cycle(); next_cycle();
      rst = 1'b0;
      chk_on = 1'b1;
      next_cycle(); next_cycle();

      // Core read of 0x10, held through its ack cycle then dropped.
      mem[32'h10] = 32'hDEADBEEF;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = 32'h0;
      cnt = 0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (mem_en) cnt++;
         if (k == 0) chk1("d1_busy_c0", busy, 1'b0);
         if (k == 1) begin
            chk1("d1_en_c1", mem_en, 1'b1);
            chk32("d1_addr_c1", mem_addr, 32'h10);
         end
         if (k <= 4) chk1("d1_stall", core_stall, 1'b1);
         if (k == 4) chk1("d1_noack_c4", ack0, 1'b0);
         if (k == 5) begin
            chk1("d1_ack_c5", ack0, 1'b1);
            chk32("d1_rdata_c5", rdata, 32'hDEADBEEF);
            chk1("d1_stall_c5", core_stall, 1'b0);
         end
         if (k == 6) chk1("d1_ack_width", ack0, 1'b0);
         next_cycle();
         if (k == 5) req0 = 1'b0;
      end
      chk32("d1_single_issue", cnt, 32'd1);

      // Loader write of 0x1234 to 0x40.
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h1234;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (mem_en && mem_we) cnt++;
         if (k == 1) begin
            chk32("d2_addr", mem_addr, 32'h40);
            chk32("d2_wdata", mem_wdata, 32'h1234);
         end
         if (k == 5) begin
            chk1("d2_ack1", ack1, 1'b1);
            chk1("d2_ack0", ack0, 1'b0);
            chk32("d2_rdata_held", rdata, 32'hDEADBEEF);
            chk1("d2_gid", grant_id, 1'b1);
         end
         if (k == 6) chk1("d2_ack_width", ack1, 1'b0);
         next_cycle();
         if (k == 5) req1 = 1'b0;
      end
      chk32("d2_write_strobes", cnt, 32'd1);

      // Simultaneous requests: requester 0 first, requester 1 starts in the ack cycle.
      mem[32'h24] = 32'hCAFEF00D;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h24;
      a0_at = -1; a1_at = -1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         s0 = ack0; s1 = ack1;
         if (s0 && a0_at < 0) a0_at = k;
         if (s1 && a1_at < 0) begin
            a1_at = k;
            chk32("d3_rdata1", rdata, 32'hCAFEF00D);
         end
         next_cycle();
         if (s0) req0 = 1'b0;
         if (s1) req1 = 1'b0;
      end
      chk32("d3_ack0_cycle", a0_at, 32'd5);
      chk32("d3_ack1_cycle", a1_at, 32'd10);

      // Reset during WAIT aborts; the held request then completes from scratch.
      mem[32'h30] = 32'h0BADF00D;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h30;
      a0_at = -1;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         s0 = ack0;
         if (s0 && a0_at < 0) begin
            a0_at = k;
            chk32("d5_rdata", rdata, 32'h0BADF00D);
         end
         if (k == 3) chk1("d5_busy_wait", busy, 1'b1);
         if (k == 4) begin
            chk1("d5_busy_after_rst", busy, 1'b0);
            chk1("d5_en_after_rst", mem_en, 1'b0);
            chk1("d5_ack_after_rst", ack0, 1'b0);
            chk32("d5_rdata_rst", rdata, 32'h0);
         end
         next_cycle();
         rst = (k == 2);
         if (s0) req0 = 1'b0;
      end
      chk32("d5_ack_cycle", a0_at, 32'd9);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         s0 = ack0; s1 = ack1;
         next_cycle();
         rst = ($urandom_range(0, 299) == 0);
         if (req0 && s0) req0 = ($urandom_range(0, 1) == 0);
         else if (req0 && $urandom_range(0, 63) == 0) req0 = 1'b0;
         else if (!req0 && $urandom_range(0, 3) == 0) req0 = 1'b1;
         if (req1 && s1) req1 = ($urandom_range(0, 1) == 0);
         else if (req1 && $urandom_range(0, 63) == 0) req1 = 1'b0;
         else if (!req1 && $urandom_range(0, 3) == 0) req1 = 1'b1;
         if (s0 || !req0 || $urandom_range(0, 7) == 0) begin
            we0 = $urandom_range(0, 2) == 0;
            addr0 = 32'($urandom_range(0, 15)) << 2;
            wdata0 = $urandom();
         end
         if (s1 || !req1 || $urandom_range(0, 7) == 0) begin
            we1 = $urandom_range(0, 1) == 0;
            addr1 = 32'($urandom_range(0, 15)) << 2;
            wdata1 = $urandom();
         end
      end

      @(negedge clk);
      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
